// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle for apb4_mem_slave: request signals from the master,
// response signals from the slave. PCLK/PRESETn stay outside the bundle.
interface apb4_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_mem_slave.sv
// APB4 scratch-RAM slave: parametrised width/depth, separate read/write
// wait states, byte-lane write strobes, clean abort when PSEL drops.
// Optional feature macro APB4_SLV_ERR_EN: when defined, misaligned or
// out-of-range addresses get PSLVERR (writes dropped, reads return 0);
// when undefined, every address aliases into memory (index modulo DEPTH).
module apb4_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int RD_WAIT    = 0,
  parameter int WR_WAIT    = 2
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb4_mem_slave_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   setup_seen;
  logic                   load_cmd;
  logic                   pready;
  logic                   err;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  idx_full;
  logic [IDX_WIDTH-1:0]   mem_idx;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  assign setup_seen = bus.PSEL && !bus.PENABLE;
  assign idx_full   = bus.PADDR >> ADDR_LSB;

`ifdef APB4_SLV_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK =
    ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  logic addr_legal;
  logic err_q;

  assign addr_legal = ((bus.PADDR & LSB_MASK) == '0) &&
                      (idx_full < ADDR_WIDTH'(DEPTH));
  // Only consulted when addr_legal holds, so the slice is always in range.
  assign mem_idx    = idx_full[IDX_WIDTH-1:0];

  // Error flag captured at the setup edge and held for the whole transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)      err_q <= 1'b0;
    else if (load_cmd) err_q <= !addr_legal;
  end

  assign err         = err_q;
  assign bus.PSLVERR = pready && err;
`else
  // Aliasing mode: low address bits are already shifted out; wrap the index.
  assign mem_idx     = IDX_WIDTH'(idx_full % ADDR_WIDTH'(DEPTH));
  assign err         = 1'b0;
  assign bus.PSLVERR = 1'b0;
`endif

  // State and wait counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait-count and PREADY decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_cmd = 1'b0;
    pready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup_seen) begin
          load_cmd = 1'b1;
          cnt_d    = bus.PWRITE ? WR_CNT : RD_CNT;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          // Master abandoned the transfer: nothing is written.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!bus.PENABLE) begin
          // A fresh setup phase without completion restarts the transfer.
          load_cmd = 1'b1;
          cnt_d    = bus.PWRITE ? WR_CNT : RD_CNT;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pready  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_en      = pready && bus.PWRITE && !err;
  assign bus.PREADY = pready;
  assign bus.PRDATA = (pready && !bus.PWRITE && !err) ? mem[mem_idx] : '0;

  // Byte-lane write into the storage array on the completing edge.
  always_ff @(posedge PCLK) begin
    // NOTE: the storage array has no reset; its contents are undefined
    // until written, and leaving it out of reset keeps it mappable to RAM.
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.PSTRB[b]) mem[mem_idx][8*b +: 8] <= bus.PWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

APB4 (AMBA 3/4) memory-mapped slave that supersedes the fixed 32×32 APB memory slave. Memory width, depth and per-direction wait states are parametrised. It adds byte-lane write strobes (PSTRB), error responses (PSLVERR) for illegal addresses, and a clean abort when a master drops PSEL mid-transfer. It sits behind the APB bridge/decoder as a scratch-RAM peripheral and is the DUT for the next-generation APB UVM environment.

## Interface
Parameters:
- DATA_WIDTH, 32: data bus width; legal values are 8, 16, 32, 64.
- ADDR_WIDTH, 32: PADDR width.
- DEPTH, 32: number of memory words; any value ≥ 2, not required to be a power of two.
- RD_WAIT, 0: wait states inserted on reads; range 0–15.
- WR_WAIT, 2: wait states inserted on writes; range 0–15.

Ports:
- PCLK  in  1  bus clock; every register is updated on its rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  marks the access phase.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  error response; only meaningful while PREADY=1.

## Operation
- Addressing:
  - ADDR_LSB = $clog2(DATA_WIDTH/8).
  - Word index idx = PADDR >> ADDR_LSB.
  - Address is legal when PADDR[ADDR_LSB-1:0] == 0 and idx < DEPTH.
- FSM states:
  - IDLE → ACCESS when a setup cycle is seen (PSEL=1, PENABLE=0). At that edge, load cnt with WR_WAIT if PWRITE=1, otherwise RD_WAIT, and latch the error flag err = !legal.
  - ACCESS with PSEL=1, PENABLE=1, cnt≠0: decrement cnt and stay in ACCESS.
  - ACCESS with PSEL=1, PENABLE=1, cnt==0: the transfer completes. Go to IDLE; a setup cycle in the next cycle is then accepted normally, giving back-to-back transfers with no idle gap.
  - ACCESS with PSEL=0: abort. Go to IDLE; no write occurs and cnt is discarded.
- Write commit:
  - Happens on the completing edge only, and only when err=0.
  - Each byte lane b with PSTRB[b]=1 takes PWDATA[8b+7:8b]; lanes with PSTRB[b]=0 are unchanged.
  - PSTRB=0 is a legal write that leaves memory unchanged.
- Read: PSTRB is ignored.
- Address and data are sampled from the live bus during the access phase. The APB rules require the master to hold them stable, and the slave does not re-check them.
- Memory contents are not reset; they are undefined until first written.
- Reset: asserting PRESETn=0 at any point, including mid-access, forces IDLE, cnt=0 and err=0 immediately. Any pending write is lost.

## Timing
Output values under reset:
- PREADY=0, PSLVERR=0, PRDATA=0.

Output equations (combinational from registered state and bus inputs):
- PREADY = (state==ACCESS) && PSEL && PENABLE && (cnt==0).
- PSLVERR = PREADY && err.
- PRDATA = mem[idx] when PREADY && !PWRITE && !err; 0 otherwise.

Latency:
- A transfer is 2+W cycles: 1 setup cycle plus W+1 access cycles, where W is the applicable wait count.
- With W=0, PREADY is high in the first access cycle.

Edge cases:
- A setup cycle on the cycle immediately after completion is accepted: setup at the edge after PREADY.
- Read-after-write to the same word returns the new data in the next transfer.

## Configuration
- APB4_SLV_ERR_EN defined:
  - PSLVERR is generated as above.
  - Illegal writes are dropped and illegal reads return 0.
- APB4_SLV_ERR_EN undefined:
  - PSLVERR is tied to 0 and err is always 0.
  - The index is taken modulo DEPTH and the PADDR low bits are ignored, so every address aliases into memory.
  - The error-flag register is not instantiated.

## Test plan
- Reset, then write 0xDEADBEEF to 0x08 with PSTRB=0xF (WR_WAIT=2). Required response: PREADY high on the 3rd access cycle, PSLVERR=0. A read of 0x08 (RD_WAIT=0) returns 0xDEADBEEF with PREADY high on the first access cycle.
- Write 0x11223344 to 0x10, then write 0xAABBCCDD to 0x10 with PSTRB=0x5. Required response: a read of 0x10 returns 0x11BB33DD.
- With APB4_SLV_ERR_EN defined:
  - Write to 0x80 (idx 32 with DEPTH=32): PSLVERR=1 with PREADY, memory unchanged.
  - Read of 0x0A (misaligned): PSLVERR=1, PRDATA=0.
- Without APB4_SLV_ERR_EN, write 0x5A5A5A5A to 0x80. Required response: PSLVERR=0, and a read of 0x00 returns 0x5A5A5A5A.
- Start a write of 0xCAFEF00D to 0x04 and deassert PSEL after 1 access cycle. In a separate run, pulse PRESETn low mid-access of the same write. Required response: a subsequent read of 0x04 returns the old value in both cases, and PREADY never asserted during the aborted transfer.
- Back-to-back: write, read, write to 0x00, 0x04, 0x08 with no idle cycles. Required response: each PREADY at its expected cycle (2+W after its setup) and all data correct.
